// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, no parity, optional stop bit.
// Emits one byte per single-cycle rx_valid pulse; frames are 9 bit-periods long.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    IDX_LAST   = 4'd8;

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [7:0]    shift;
    logic          rxd_m;
    logic          rxd_s;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    // The detecting edge is count 0 of the start bit, so RECV
                    // resumes at 1 and the whole frame spans 9*CLKS_PER_BIT clocks.
                    if (!rxd_s) begin
                        state <= RECV;
                        cnt   <= CW'(1);
                    end
                end
                RECV: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end

                    if (cnt == CNT_SAMPLE) begin
                        if (idx == 4'd0) begin
                            if (rxd_s) begin
                                state <= IDLE;
                                cnt   <= '0;
                                idx   <= '0;
                            end
                        end else begin
                            shift <= {rxd_s, shift[7:1]};
                            if (idx == IDX_LAST) begin
                                rx_data  <= {rxd_s, shift[7:1]};
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at the default 16 clocks per bit (160 ns/bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run = 0;
    int max_run = 0;
    logic [7:0] pq_data[$];
    int         pq_cyc[$];

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Record every cycle rx_valid is seen high, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            pq_data.push_back(rx_data);
            pq_cyc.push_back(cyc);
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic clear_log();
        pq_data.delete();
        pq_cyc.delete();
        max_run = 0;
    endtask

    task automatic send_frame(input logic [7:0] b);
        rxd = 1'b0;
        #160;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #160;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        rxd   = 1'b1;
        #3;
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_during got %h expected 00", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_during got %b expected 0", rx_valid);
        end
        #4;
        n_rst = 1'b1;
        #3;
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_after got %h expected 00", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_after got %b expected 0", rx_valid);
        end
        #11;
        checks++;
        if (pq_data.size() != 0) begin
            errors++;
            $display("FAIL reset_idle_pulses got %0d expected 0", pq_data.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [12];
        seq = '{8'h49, 8'h20, 8'h53, 8'h31, 8'h32, 8'h33,
                8'h34, 8'h2B, 8'h35, 8'h36, 8'h37, 8'h38};
        clear_log();
        for (int i = 0; i < 12; i++) send_frame(seq[i]);
        rxd = 1'b1;
        #500;
        checks++;
        if (pq_data.size() != 12) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 12", pq_data.size());
        end
        for (int i = 0; i < 12 && i < pq_data.size(); i++) begin
            checks++;
            if (pq_data[i] !== seq[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d got %h expected %h", i, pq_data[i], seq[i]);
            end
        end
        if (pq_cyc.size() > 0) begin
            checks++;
            if (pq_cyc[0] != 140) begin
                errors++;
                $display("FAIL b2b_first_latency got cycle %0d expected 140", pq_cyc[0]);
            end
        end
        for (int i = 1; i < pq_cyc.size(); i++) begin
            checks++;
            if (pq_cyc[i] - pq_cyc[i-1] != 144) begin
                errors++;
                $display("FAIL b2b_spacing%0d got %0d expected 144", i, pq_cyc[i] - pq_cyc[i-1]);
            end
        end
        checks++;
        if (max_run != 1) begin
            errors++;
            $display("FAIL b2b_pulse_width got %0d expected 1", max_run);
        end
    endtask

    task automatic test_standard_framing();
        clear_log();
        send_frame(8'h3D);
        rxd = 1'b1;
        #960;
        send_frame(8'h2A);
        rxd = 1'b1;
        #960;
        #2000;
        checks++;
        if (pq_data.size() != 2) begin
            errors++;
            $display("FAIL std_count got %0d expected 2", pq_data.size());
        end
        if (pq_data.size() >= 2) begin
            checks++;
            if (pq_data[0] !== 8'h3D) begin
                errors++;
                $display("FAIL std_byte0 got %h expected 3d", pq_data[0]);
            end
            checks++;
            if (pq_data[1] !== 8'h2A) begin
                errors++;
                $display("FAIL std_byte1 got %h expected 2a", pq_data[1]);
            end
        end
        checks++;
        if (rx_data !== 8'h2A) begin
            errors++;
            $display("FAIL std_hold got %h expected 2a", rx_data);
        end
        checks++;
        if (max_run != 1) begin
            errors++;
            $display("FAIL std_pulse_width got %0d expected 1", max_run);
        end
    endtask

    task automatic test_false_start();
        clear_log();
        rxd = 1'b0;
        #40;
        rxd = 1'b1;
        #600;
        checks++;
        if (pq_data.size() != 0) begin
            errors++;
            $display("FAIL false_start_pulses got %0d expected 0", pq_data.size());
        end
        send_frame(8'h57);
        rxd = 1'b1;
        #960;
        checks++;
        if (pq_data.size() != 1) begin
            errors++;
            $display("FAIL after_false_count got %0d expected 1", pq_data.size());
        end
        if (pq_data.size() >= 1) begin
            checks++;
            if (pq_data[0] !== 8'h57) begin
                errors++;
                $display("FAIL after_false_byte got %h expected 57", pq_data[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h2F;
        clear_log();
        checks++;
        if (rx_data !== 8'h57) begin
            errors++;
            $display("FAIL pre_reset_data got %h expected 57", rx_data);
        end
        rxd = 1'b0;
        #160;
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            #160;
        end
        rxd = b[4];
        #80;
        n_rst = 1'b0;
        #1;
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_data got %h expected 00", rx_data);
        end
        #79;
        for (int i = 5; i < 8; i++) begin
            rxd = b[i];
            #160;
        end
        rxd = 1'b1;
        #360;
        n_rst = 1'b1;
        #800;
        checks++;
        if (pq_data.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pulses got %0d expected 0", pq_data.size());
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_data got %h expected 00", rx_data);
        end
        send_frame(8'h2D);
        rxd = 1'b1;
        #960;
        checks++;
        if (pq_data.size() != 1) begin
            errors++;
            $display("FAIL post_reset_count got %0d expected 1", pq_data.size());
        end
        if (pq_data.size() >= 1) begin
            checks++;
            if (pq_data[0] !== 8'h2D) begin
                errors++;
                $display("FAIL post_reset_byte got %h expected 2d", pq_data[0]);
            end
        end
    endtask

    task automatic test_stuck_low();
        logic [7:0] exp [4];
        exp = '{8'h31, 8'h00, 8'h00, 8'h00};
        clear_log();
        send_frame(8'h31);
        rxd = 1'b0;
        #(3 * 1440);
        rxd = 1'b1;
        #1000;
        checks++;
        if (pq_data.size() != 4) begin
            errors++;
            $display("FAIL stuck_count got %0d expected 4", pq_data.size());
        end
        for (int i = 0; i < 4 && i < pq_data.size(); i++) begin
            checks++;
            if (pq_data[i] !== exp[i]) begin
                errors++;
                $display("FAIL stuck_byte%0d got %h expected %h", i, pq_data[i], exp[i]);
            end
        end
        for (int i = 1; i < pq_cyc.size(); i++) begin
            checks++;
            if (pq_cyc[i] - pq_cyc[i-1] != 144) begin
                errors++;
                $display("FAIL stuck_spacing%0d got %0d expected 144", i, pq_cyc[i] - pq_cyc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_standard_framing();
        test_false_start();
        test_reset_mid_frame();
        test_stuck_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
